dp_tap_ctrl: RTL and testbench

- JTAG TAP controller for the debug port: IEEE 1149.1 16-state FSM plus a 5-bit instruction register (IR) shift/update path.
- Drives dp_ir_dec with the current instruction on ir_out.
- Generates capture/shift/update strobes for the selected data register (IDCODE, DTMCS, DMI, BYPASS).
- Muxes IR or DR serial data onto tdo.

---
 rtl/dp_tap_ctrl_pkg.sv | 57 +++++
 rtl/dp_tap_fsm.sv | 50 +++++
 rtl/dp_tap_ctrl.sv | 80 ++++++++
 tb/tb_dp_tap_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_tap_ctrl_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, IR width and the
// instruction codes understood by dp_ir_dec.
package dp_tap_ctrl_pkg;

  localparam int TAP_IR_W = 5;

  localparam logic [TAP_IR_W-1:0] IR_IDCODE = 5'h01;
  localparam logic [TAP_IR_W-1:0] IR_DTMCS  = 5'h10;
  localparam logic [TAP_IR_W-1:0] IR_DMI    = 5'h11;
  localparam logic [TAP_IR_W-1:0] IR_BYPASS = 5'h1F;

  // Codes follow the 1149.1 recommended state assignment.
  typedef enum logic [3:0] {
    TAP_EXIT2_DR  = 4'h0,
    TAP_EXIT1_DR  = 4'h1,
    TAP_SHIFT_DR  = 4'h2,
    TAP_PAUSE_DR  = 4'h3,
    TAP_SEL_IR    = 4'h4,
    TAP_UPD_DR    = 4'h5,
    TAP_CAP_DR    = 4'h6,
    TAP_SEL_DR    = 4'h7,
    TAP_EXIT2_IR  = 4'h8,
    TAP_EXIT1_IR  = 4'h9,
    TAP_SHIFT_IR  = 4'hA,
    TAP_PAUSE_IR  = 4'hB,
    TAP_RTI       = 4'hC,
    TAP_UPD_IR    = 4'hD,
    TAP_CAP_IR    = 4'hE,
    TAP_TLR       = 4'hF
  } tap_state_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    unique case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dp_tap_fsm.sv
// 1149.1 TAP state register with registered Moore strobes for the DR owners.
module dp_tap_fsm
  import dp_tap_ctrl_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       tlr_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o
);

  tap_state_e state_q;
  tap_state_e state_d;
  logic       tlr_q;
  logic       capture_dr_q;
  logic       shift_dr_q;
  logic       update_dr_q;

  always_comb begin
    state_d = tap_next(state_q, tms_i);
  end

  // Strobes are registered from the next state so they always equal a
  // decode of state_q, without a combinational path to the outputs.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q      <= TAP_TLR;
      tlr_q        <= 1'b1;
      capture_dr_q <= 1'b0;
      shift_dr_q   <= 1'b0;
      update_dr_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tlr_q        <= (state_d == TAP_TLR);
      capture_dr_q <= (state_d == TAP_CAP_DR);
      shift_dr_q   <= (state_d == TAP_SHIFT_DR);
      update_dr_q  <= (state_d == TAP_UPD_DR);
    end
  end

  assign state_o      = state_q;
  assign tlr_o        = tlr_q;
  assign capture_dr_o = capture_dr_q;
  assign shift_dr_o   = shift_dr_q;
  assign update_dr_o  = update_dr_q;

endmodule

// File: rtl/dp_tap_ctrl.sv
// Debug-port TAP controller: state machine, instruction register path and
// the registered tdo mux between IR and the selected DR.
module dp_tap_ctrl
  import dp_tap_ctrl_pkg::*;
#(
  parameter int                IR_W       = TAP_IR_W,
  parameter logic [IR_W-1:0]   IR_RESET   = IR_IDCODE,
  parameter logic [IR_W-1:0]   IR_CAPTURE = 5'b00001
) (
  input  logic            tck,
  input  logic            trst,
  input  logic            tms,
  input  logic            tdi,
  input  logic            dr_tdo,
  output logic            tdo,
  output logic            tdo_oe,
  output logic [IR_W-1:0] ir_out,
  output logic [3:0]      tap_state,
  output logic            tlr,
  output logic            capture_dr,
  output logic            shift_dr,
  output logic            update_dr
);

  tap_state_e      state;
  logic [IR_W-1:0] ir_sh_q;
  logic [IR_W-1:0] ir_out_q;
  logic            tdo_q;
  logic            tdo_oe_q;

  dp_tap_fsm u_fsm (
    .tck_i        (tck),
    .trst_i       (trst),
    .tms_i        (tms),
    .state_o      (state),
    .tlr_o        (tlr),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr)
  );

  // ir_out only moves in Update-IR or Test-Logic-Reset, so a DR scan
  // (including Pause/Exit loops) always sees a stable instruction.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sh_q  <= IR_RESET;
      ir_out_q <= IR_RESET;
    end else begin
      unique case (state)
        TAP_CAP_IR:   ir_sh_q  <= IR_CAPTURE;
        TAP_SHIFT_IR: ir_sh_q  <= {tdi, ir_sh_q[IR_W-1:1]};
        TAP_UPD_IR:   ir_out_q <= ir_sh_q;
        TAP_TLR:      ir_out_q <= IR_RESET;
        default: ;
      endcase
    end
  end

  // tdo lags the shifted bit by one tck; it holds its last value when idle.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else if (state == TAP_SHIFT_IR) begin
      tdo_q    <= ir_sh_q[0];
      tdo_oe_q <= 1'b1;
    end else if (state == TAP_SHIFT_DR) begin
      tdo_q    <= dr_tdo;
      tdo_oe_q <= 1'b1;
    end else begin
      tdo_oe_q <= 1'b0;
    end
  end

  assign tdo       = tdo_q;
  assign tdo_oe    = tdo_oe_q;
  assign ir_out    = ir_out_q;
  assign tap_state = state;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Bench for dp_tap_ctrl: reset, vector-table IR load, directed multi-cycle
// corner cases and a randomized run against a behavioural TAP model.
module tb_dp_tap_ctrl;

  logic       tck = 1'b0;
  logic       trst = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       dr_tdo = 1'b0;
  logic       tdo;
  logic       tdo_oe;
  logic [4:0] ir_out;
  logic [3:0] tap_state;
  logic       tlr;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;

  int total = 0;
  int bad = 0;

  dp_tap_ctrl dut (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .tdi        (tdi),
    .dr_tdo     (dr_tdo),
    .tdo        (tdo),
    .tdo_oe     (tdo_oe),
    .ir_out     (ir_out),
    .tap_state  (tap_state),
    .tlr        (tlr),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );

  // clock / reset
  initial forever #5 tck = ~tck;

  // state codes from the 1149.1 recommended assignment
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_SELIR = 4'h4;
  localparam logic [3:0] S_CAPDR = 4'h6, S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR = 4'h3;
  localparam logic [3:0] S_E2DR = 4'h0, S_UPDR = 4'h5, S_CAPIR = 4'hE, S_SHIR = 4'hA;
  localparam logic [3:0] S_E1IR = 4'h9, S_PIR = 4'hB, S_E2IR = 4'h8, S_UPIR = 4'hD;

  // behavioural reference model
  logic [3:0] m_state;
  logic [4:0] m_sh, m_ir;
  logic       m_tdo, m_oe;

  function automatic logic [3:0] m_next(input logic [3:0] s, input logic t);
    case (s)
      S_TLR:   return t ? S_TLR   : S_RTI;
      S_RTI:   return t ? S_SELDR : S_RTI;
      S_SELDR: return t ? S_SELIR : S_CAPDR;
      S_SELIR: return t ? S_TLR   : S_CAPIR;
      S_CAPDR: return t ? S_E1DR  : S_SHDR;
      S_SHDR:  return t ? S_E1DR  : S_SHDR;
      S_E1DR:  return t ? S_UPDR  : S_PDR;
      S_PDR:   return t ? S_E2DR  : S_PDR;
      S_E2DR:  return t ? S_UPDR  : S_SHDR;
      S_UPDR:  return t ? S_SELDR : S_RTI;
      S_CAPIR: return t ? S_E1IR  : S_SHIR;
      S_SHIR:  return t ? S_E1IR  : S_SHIR;
      S_E1IR:  return t ? S_UPIR  : S_PIR;
      S_PIR:   return t ? S_E2IR  : S_PIR;
      S_E2IR:  return t ? S_UPIR  : S_SHIR;
      S_UPIR:  return t ? S_SELDR : S_RTI;
      default: return S_TLR;
    endcase
  endfunction

  task automatic m_reset();
    m_state = S_TLR;
    m_sh = 5'h01;
    m_ir = 5'h01;
    m_tdo = 1'b0;
    m_oe = 1'b0;
  endtask

  task automatic m_step(input logic t, input logic d, input logic drv);
    if (m_state == S_SHIR) begin
      m_tdo = m_sh[0];
      m_oe = 1'b1;
    end else if (m_state == S_SHDR) begin
      m_tdo = drv;
      m_oe = 1'b1;
    end else begin
      m_oe = 1'b0;
    end
    if (m_state == S_CAPIR) m_sh = 5'h01;
    else if (m_state == S_SHIR) m_sh = (m_sh >> 1) | (5'(d) << 4);
    if (m_state == S_UPIR) m_ir = m_sh;
    else if (m_state == S_TLR) m_ir = 5'h01;
    m_state = m_next(m_state, t);
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, 32'(tap_state), 32'(m_state));
    chk({tag, ".ir_out"}, 32'(ir_out), 32'(m_ir));
    chk({tag, ".tdo"}, 32'(tdo), 32'(m_tdo));
    chk({tag, ".tdo_oe"}, 32'(tdo_oe), 32'(m_oe));
    chk({tag, ".tlr"}, 32'(tlr), 32'(m_state == S_TLR));
    chk({tag, ".capture_dr"}, 32'(capture_dr), 32'(m_state == S_CAPDR));
    chk({tag, ".shift_dr"}, 32'(shift_dr), 32'(m_state == S_SHDR));
    chk({tag, ".update_dr"}, 32'(update_dr), 32'(m_state == S_UPDR));
  endtask

  // driver tasks: inputs change between rising edges, outputs are sampled on the falling edge
  task automatic step(input logic t, input logic d, input logic drv);
    tms = t;
    tdi = d;
    dr_tdo = drv;
    m_step(t, d, drv);
    @(posedge tck);
    @(negedge tck);
  endtask

  task automatic do_reset(input string tag);
    tms = 1'b0;
    tdi = 1'b0;
    dr_tdo = 1'b0;
    #1 trst = 1'b1;
    m_reset();
    #1;
    chk({tag, ".state"}, 32'(tap_state), 32'(S_TLR));
    chk({tag, ".ir_out"}, 32'(ir_out), 32'h01);
    chk({tag, ".tdo_oe"}, 32'(tdo_oe), 32'h0);
    chk({tag, ".tlr"}, 32'(tlr), 32'h1);
    trst = 1'b0;
  endtask

  task automatic ir_scan(input logic [4:0] val);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(i == 4, val[i], 0);
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic [4:0] ir;
    logic       tdo;
    logic       oe;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int ncap, nsh, nup;
    logic [15:0] oe_mask;
    logic prev_tdi, cur_tdi;

    vecs[0]  = '{1'b1, 1'b0, S_SELDR, 5'h01, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, S_SELIR, 5'h01, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, S_CAPIR, 5'h01, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, S_SHIR,  5'h01, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, S_SHIR,  5'h01, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, S_SHIR,  5'h01, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, S_SHIR,  5'h01, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, S_SHIR,  5'h01, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, S_E1IR,  5'h01, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, S_UPIR,  5'h01, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, S_RTI,   5'h11, 1'b0, 1'b0};

    @(negedge tck);
    do_reset("reset");
    step(0, 0, 0);
    chk("reset_rti.state", 32'(tap_state), 32'(S_RTI));
    chk("reset_rti.ir_out", 32'(ir_out), 32'h01);
    chk("reset_rti.tdo_oe", 32'(tdo_oe), 32'h0);
    chk("reset_rti.tlr", 32'(tlr), 32'h0);

    // IR load of DMI from the vector table
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].tms, vecs[i].tdi, 0);
      chk($sformatf("dmi[%0d].state", i), 32'(tap_state), 32'(vecs[i].st));
      chk($sformatf("dmi[%0d].ir_out", i), 32'(ir_out), 32'(vecs[i].ir));
      chk($sformatf("dmi[%0d].tdo", i), 32'(tdo), 32'(vecs[i].tdo));
      chk($sformatf("dmi[%0d].tdo_oe", i), 32'(tdo_oe), 32'(vecs[i].oe));
    end

    // five tms=1 edges from Shift-DR reach TLR; four do not
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("sync.in_shift_dr", 32'(tap_state), 32'(S_SHDR));
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("sync.four_not_tlr", 32'(tap_state == S_TLR), 32'h0);
    chk("sync.four_tlr_flag", 32'(tlr), 32'h0);
    chk("sync.ir_kept", 32'(ir_out), 32'h11);
    step(1, 0, 0);
    chk("sync.five_tlr", 32'(tlr), 32'h1);
    chk("sync.five_state", 32'(tap_state), 32'(S_TLR));
    step(1, 0, 0);
    chk("sync.ir_reset", 32'(ir_out), 32'h01);
    step(0, 0, 0);
    check_model("sync_rti");

    // IR scan of DTMCS interrupted by Pause
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("pause.exit1", 32'(tap_state), 32'(S_E1IR));
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("pause.paused", 32'(tap_state), 32'(S_PIR));
    chk("pause.ir_hold", 32'(ir_out), 32'h01);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("pause.ir_out", 32'(ir_out), 32'h10);
    check_model("pause_rti");

    // DR scan with BYPASS selected and dr_tdo = delayed tdi
    ir_scan(5'h1F);
    chk("bypass.ir_out", 32'(ir_out), 32'h1F);
    step(1, 0, 0);
    ncap = 0; nsh = 0; nup = 0; oe_mask = '0; prev_tdi = 1'b0;
    step(0, 0, 0);
    ncap += int'(capture_dr);
    nsh += int'(shift_dr);
    nup += int'(update_dr);
    if (tdo_oe) oe_mask[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cur_tdi = 1'($urandom_range(0, 1));
      step((k == 9) || (k == 10), cur_tdi, prev_tdi);
      if (k >= 2 && k <= 9) chk($sformatf("dr.tdo[%0d]", k), 32'(tdo), 32'(prev_tdi));
      prev_tdi = cur_tdi;
      ncap += int'(capture_dr);
      nsh += int'(shift_dr);
      nup += int'(update_dr);
      if (tdo_oe) oe_mask[k] = 1'b1;
    end
    chk("dr.capture_cycles", 32'(ncap), 32'd1);
    chk("dr.shift_cycles", 32'(nsh), 32'd8);
    chk("dr.update_cycles", 32'(nup), 32'd1);
    chk("dr.oe_window", 32'(oe_mask), 32'h03FC);
    chk("dr.ir_stable", 32'(ir_out), 32'h1F);
    chk("dr.back_rti", 32'(tap_state), 32'(S_RTI));

    // trst in the middle of an IR shift of DMI
    do_reset("abort_pre");
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("abort.oe_before", 32'(tdo_oe), 32'h1);
    do_reset("abort");
    step(1, 1, 0);
    step(0, 0, 0);
    chk("abort.ir_not_committed", 32'(ir_out), 32'h01);
    check_model("abort_rti");

    // randomized run against the model, with an occasional async reset
    do_reset("rand_reset");
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 199) do_reset("rand_reset");
      step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_model($sformatf("rand[%0d]", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
